// File: rtl/fetch_prefetch_queue_if.sv
// Prefetch queue bus bundle: redirect input, instruction-memory request/response
// channel, and the valid/ready hand-off to Fetch.
//   master : the prefetch queue (drives memRequest/memAddress and the out* head)
//   slave  : the surrounding core/memory (drives redirect, memory response, outReady)
interface fetch_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned OccWidth = $clog2(DEPTH + 1);

    logic                redirectValid;
    logic [31:0]         redirectAddress;
    logic                memRequest;
    logic [31:0]         memAddress;
    logic                memValid;
    logic [31:0]         memData;
    logic                outValid;
    logic                outReady;
    logic [31:0]         outInstruction;
    logic [31:0]         outProgramCounter;
    logic [OccWidth-1:0] occupancy;

    modport master (
        input  redirectValid, redirectAddress, memValid, memData, outReady,
        output memRequest, memAddress, outValid, outInstruction, outProgramCounter, occupancy
    );

    modport slave (
        output redirectValid, redirectAddress, memValid, memData, outReady,
        input  memRequest, memAddress, outValid, outInstruction, outProgramCounter, occupancy
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue. Issues sequential word fetches to instruction
// memory, buffers {pc, instr} pairs in a circular buffer and hands the head to
// Fetch over valid/ready. A redirect flushes the buffer and restarts at the
// word-aligned target; a response still in flight at redirect time is dropped.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : fetch_prefetch_queue_if.master (redirect, memory, Fetch side)
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccWidth = $clog2(DEPTH + 1);

    // RUN: idle, WAIT: response will be kept, DISCARD: response will be dropped
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t              state;
    logic [31:0]         pcStore    [DEPTH];
    logic [31:0]         instrStore [DEPTH];
    logic [PtrWidth-1:0] readPtr;
    logic [PtrWidth-1:0] writePtr;
    logic [OccWidth-1:0] occupancy;
    logic [OccWidth-1:0] occupancyNext;
    logic [31:0]         fetchPC;
    logic [31:0]         memAddress;
    logic                memRequest;
    logic                outValid;
    logic                push;
    logic                pop;
    logic                issue;
    logic [31:0]         redirectTarget;
    logic                unusedAddressBits;

    // Per-cycle push/pop/issue decisions; a redirect overrides all of them.
    always_comb begin
        redirectTarget = {bus.redirectAddress[31:2], 2'b00};
        pop            = outValid && bus.outReady && !bus.redirectValid;
        push           = (state == WAIT) && bus.memValid && !bus.redirectValid;
        // Only issued from RUN, so no request is outstanding and a free slot is guaranteed.
        issue          = (state == RUN) && !bus.redirectValid && (occupancy < OccWidth'(DEPTH));
        occupancyNext  = occupancy;
        if (bus.redirectValid) begin
            occupancyNext = '0;
        end else if (push && !pop) begin
            occupancyNext = occupancy + OccWidth'(1);
        end else if (pop && !push) begin
            occupancyNext = occupancy - OccWidth'(1);
        end
    end

    // Request FSM, fetch PC and circular buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            readPtr    <= '0;
            writePtr   <= '0;
            occupancy  <= '0;
            outValid   <= 1'b0;
            memRequest <= 1'b0;
            memAddress <= RESET_VECTOR;
            fetchPC    <= RESET_VECTOR;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pcStore[i]    <= '0;
                instrStore[i] <= '0;
            end
        end else begin
            memRequest <= issue;
            occupancy  <= occupancyNext;
            outValid   <= (occupancyNext != '0);

            if (bus.redirectValid) begin
                readPtr  <= '0;
                writePtr <= '0;
                fetchPC  <= redirectTarget;
            end else begin
                if (issue) begin
                    memAddress <= fetchPC;
                    fetchPC    <= fetchPC + 32'd4;
                end
                if (push) begin
                    pcStore[writePtr]    <= memAddress;
                    instrStore[writePtr] <= bus.memData;
                    writePtr             <= writePtr + PtrWidth'(1);
                end
                if (pop) begin
                    readPtr <= readPtr + PtrWidth'(1);
                end
            end

            // A response always retires the outstanding request, even alongside a redirect.
            case (state)
                RUN: begin
                    if (issue) state <= WAIT;
                end
                WAIT: begin
                    if (bus.memValid)           state <= RUN;
                    else if (bus.redirectValid) state <= DISCARD;
                end
                DISCARD: begin
                    if (bus.memValid) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign unusedAddressBits     = ^bus.redirectAddress[1:0];
    assign bus.memRequest        = memRequest;
    assign bus.memAddress        = memAddress;
    assign bus.outValid          = outValid;
    assign bus.occupancy         = occupancy;
    assign bus.outInstruction    = instrStore[readPtr];
    assign bus.outProgramCounter = pcStore[readPtr];
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model: queue contents plus the single in-flight request.
    entry_t      mQ[$];
    logic [31:0] mFetchPC;
    logic [31:0] mAddr;
    bit          mOut;
    bit          mKeep;
    bit          mReq;

    // Memory responder state.
    bit          respPending;
    int          respDelay;
    int          memLat;

    logic [31:0] reqLog[$];
    logic [31:0] popLog[$];
    int          assertions;
    int          failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mFetchPC = 32'h0;
        mAddr    = 32'h0;
        mOut     = 0;
        mKeep    = 0;
        mReq     = 0;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset               = 1'b1;
        bus.redirectValid   = 1'b0;
        bus.redirectAddress = 32'h0;
        bus.memValid        = 1'b0;
        bus.memData         = 32'h0;
        bus.outReady        = 1'b0;
        #1;
        check("rst_memRequest", 32'(bus.memRequest), 32'h0);
        check("rst_memAddress", bus.memAddress, 32'h0);
        check("rst_outValid", 32'(bus.outValid), 32'h0);
        check("rst_outInstruction", bus.outInstruction, 32'h0);
        check("rst_outPC", bus.outProgramCounter, 32'h0);
        check("rst_occupancy", 32'(bus.occupancy), 32'h0);
        @(posedge clock);
        #1;
        modelReset();
    endtask

    // One clock: drive inputs, advance the model by the same rules, then compare.
    task automatic cycle(input bit redirect, input logic [31:0] target, input bit ready);
        bit          mv;
        logic [31:0] md;
        bit          popping;
        bit          issuing;
        @(negedge clock);
        reset = 1'b0;
        mv    = 0;
        md    = $urandom();
        if (respPending) begin
            if (respDelay == 0) begin
                mv          = 1;
                respPending = 0;
            end else begin
                respDelay--;
            end
        end
        bus.redirectValid   = redirect;
        bus.redirectAddress = target;
        bus.outReady        = ready;
        bus.memValid        = mv;
        bus.memData         = md;
        if (bus.outValid && ready && !redirect) popLog.push_back(bus.outProgramCounter);

        popping = (mQ.size() != 0) && ready && !redirect;
        issuing = !mOut && !redirect && (mQ.size() < int'(DEPTH));
        mReq    = 0;
        if (redirect) begin
            mQ.delete();
            mFetchPC = {target[31:2], 2'b00};
            if (mOut) begin
                if (mv) mOut = 0;
                else    mKeep = 0;
            end
        end else begin
            if (popping) void'(mQ.pop_front());
            if (mOut && mv) begin
                if (mKeep) mQ.push_back('{pc: mAddr, instr: md});
                mOut = 0;
            end
            if (issuing) begin
                mOut     = 1;
                mKeep    = 1;
                mAddr    = mFetchPC;
                mFetchPC = mFetchPC + 32'd4;
                mReq     = 1;
            end
        end

        @(posedge clock);
        #1;
        if (bus.memRequest) reqLog.push_back(bus.memAddress);
        if (mReq) begin
            respPending = 1;
            respDelay   = memLat;
        end
        check("memRequest", 32'(bus.memRequest), 32'(mReq));
        check("memAddress", bus.memAddress, mAddr);
        check("occupancy", 32'(bus.occupancy), 32'(mQ.size()));
        check("outValid", 32'(bus.outValid), 32'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            check("outProgramCounter", bus.outProgramCounter, mQ[0].pc);
            check("outInstruction", bus.outInstruction, mQ[0].instr);
        end
    endtask

    function automatic logic [31:0] logAt(input int which, input int idx);
        if (which == 0) return (reqLog.size() > idx) ? reqLog[idx] : 32'hDEAD_BEEF;
        return (popLog.size() > idx) ? popLog[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bit found;
        reset               = 1'b1;
        bus.redirectValid   = 1'b0;
        bus.redirectAddress = 32'h0;
        bus.memValid        = 1'b0;
        bus.memData         = 32'h0;
        bus.outReady        = 1'b0;
        assertions          = 0;
        failures            = 0;
        respPending         = 0;
        respDelay           = 0;
        memLat              = 1;
        modelReset();

        // Sequential fetch with a one-cycle memory and an always-ready Fetch.
        doReset();
        reqLog.delete();
        popLog.delete();
        repeat (20) cycle(0, 32'h0, 1);
        check("seq_req0", logAt(0, 0), 32'h0);
        check("seq_req1", logAt(0, 1), 32'h4);
        check("seq_req2", logAt(0, 2), 32'h8);
        check("seq_pop0", logAt(1, 0), 32'h0);
        check("seq_pop1", logAt(1, 1), 32'h4);
        check("seq_pop2", logAt(1, 2), 32'h8);

        // Fetch stalled: the queue fills and requests stop.
        doReset();
        reqLog.delete();
        repeat (30) cycle(0, 32'h0, 0);
        check("full_reqCount", 32'(reqLog.size()), 32'd4);
        check("full_occupancy", 32'(bus.occupancy), 32'd4);
        check("full_memRequest", 32'(bus.memRequest), 32'd0);
        reqLog.delete();
        for (int i = 0; i < 20 && reqLog.size() == 0; i++) cycle(0, 32'h0, 1);
        check("full_resume", logAt(0, 0), 32'h10);

        // Redirect while the request to 0x8 is outstanding.
        memLat = 3;
        doReset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (mOut && mAddr == 32'h8) begin
                found = 1;
                break;
            end
            cycle(0, 32'h0, 1);
        end
        check("redirWait_found", 32'(found), 32'h1);
        cycle(1, 32'h100, 1);
        reqLog.delete();
        popLog.delete();
        for (int i = 0; i < 40 && popLog.size() == 0; i++) cycle(0, 32'h0, 1);
        check("redirWait_req", logAt(0, 0), 32'h100);
        check("redirWait_pc", logAt(1, 0), 32'h100);

        // Redirect to an unaligned target with two entries queued.
        memLat = 1;
        doReset();
        for (int i = 0; i < 40 && mQ.size() != 2; i++) cycle(0, 32'h0, 0);
        check("redirFull_pre", 32'(bus.occupancy), 32'd2);
        cycle(1, 32'h203, 0);
        check("redirFull_occ", 32'(bus.occupancy), 32'd0);
        check("redirFull_valid", 32'(bus.outValid), 32'd0);
        reqLog.delete();
        for (int i = 0; i < 20 && reqLog.size() == 0; i++) cycle(0, 32'h0, 0);
        check("redirFull_req", logAt(0, 0), 32'h200);

        // Redirect in the same cycle as the response: word must not be pushed.
        doReset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (respPending && respDelay == 0 && mOut && mKeep) begin
                found = 1;
                break;
            end
            cycle(0, 32'h0, 0);
        end
        check("redirResp_found", 32'(found), 32'h1);
        cycle(1, 32'h400, 0);
        check("redirResp_occ", 32'(bus.occupancy), 32'd0);
        reqLog.delete();
        for (int i = 0; i < 20 && reqLog.size() == 0; i++) cycle(0, 32'h0, 0);
        check("redirResp_req", logAt(0, 0), 32'h400);

        // Fetch PC wraps past the top of the address space.
        doReset();
        cycle(1, 32'hFFFF_FFFC, 1);
        reqLog.delete();
        for (int i = 0; i < 40 && reqLog.size() < 2; i++) cycle(0, 32'h0, 1);
        check("wrap_req0", logAt(0, 0), 32'hFFFF_FFFC);
        check("wrap_req1", logAt(0, 1), 32'h0000_0000);

        // Reset with a request in flight: the late response lands in RUN and is ignored.
        memLat = 0;
        doReset();
        for (int i = 0; i < 10 && !mReq; i++) cycle(0, 32'h0, 0);
        doReset();
        cycle(0, 32'h0, 0);
        check("lateResp_occ", 32'(bus.occupancy), 32'd0);
        repeat (6) cycle(0, 32'h0, 0);

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            memLat = $urandom_range(0, 3);
            tgt    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom();
            if ($urandom_range(0, 499) == 0) doReset();
            cycle($urandom_range(0, 19) == 0, tgt, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
